// File: rtl/fsa_mask_stream_mc.sv
// Multi-region mask streamer: scans a frame, reads a per-column profile, and emits a
// per-pixel class code as AXI4-Stream video. Optional hit counters: FSA_MASK_HITCNT_EN.
module fsa_mask_stream_mc #(
  parameter int C_IMG_WW  = 12,
  parameter int C_IMG_HW  = 12,
  parameter int C_CH      = 4,
  parameter int C_OUT_DW  = 8,
  parameter int C_RD_LAT  = 3,
  parameter int C_FIFO_AW = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_IMG_WW-1:0]           width,
  input  logic [C_IMG_HW-1:0]           height,
  input  logic                          fsync,
  input  logic [C_CH-1:0]               reg_valid,
  input  logic [C_CH-1:0]               reg_mode,
  input  logic [C_CH*C_IMG_WW-1:0]      reg_x0,
  input  logic [C_CH*C_IMG_WW-1:0]      reg_x1,
  input  logic [C_CH*C_IMG_HW-1:0]      reg_y0,
  input  logic [C_CH*C_IMG_HW-1:0]      reg_y1,
  input  logic [C_CH*C_OUT_DW-1:0]      reg_code,
  output logic                          rd_sof,
  output logic                          rd_en,
  output logic [C_IMG_WW-1:0]           rd_addr,
  input  logic [2*C_IMG_HW:0]           rd_data,
  output logic                          m_axis_tvalid,
  output logic [C_OUT_DW-1:0]           m_axis_tdata,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready
`ifdef FSA_MASK_HITCNT_EN
  ,
  output logic [C_CH*(C_IMG_WW+C_IMG_HW)-1:0] hit_cnt,
  output logic                          hit_cnt_vld
`endif
);

  localparam int DEPTH = 1 << C_FIFO_AW;
  localparam int IW    = C_FIFO_AW + 1;
  localparam int CW    = C_FIFO_AW + 2;
  localparam int FW    = C_OUT_DW + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                 state_q;
  logic                   pend_q;
  logic [C_IMG_WW-1:0]    w_q, px_q, rd_addr_q;
  logic [C_IMG_HW-1:0]    h_q, py_q, rd_py_q;
  logic                   rd_en_q, rd_sof_q;
  logic [C_CH-1:0]        sv_q, sm_q;
  logic [C_CH*C_IMG_WW-1:0] sx0_q, sx1_q;
  logic [C_CH*C_IMG_HW-1:0] sy0_q, sy1_q;
  logic [C_CH*C_OUT_DW-1:0] sc_q;
  logic [IW-1:0]          infl_q, fcnt_q;
  logic [C_FIFO_AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]          free_w;
  logic                   issue, dims_ok, start_req, drained, go, x_wrap, last_px;

  assign dims_ok   = (width != '0) && (height != '0);
  assign start_req = fsync | pend_q;
  assign drained   = (infl_q == '0);
  assign go        = start_req && dims_ok &&
                     ((state_q == S_IDLE) || ((state_q == S_DRAIN) && drained));
  // Free slots count reads still in flight, so the FIFO can never be overrun.
  assign free_w    = CW'(DEPTH) - CW'(fcnt_q) - CW'(infl_q);
  assign issue     = (state_q == S_RUN) && (free_w >= CW'(C_RD_LAT + 3));
  assign x_wrap    = (px_q == w_q - C_IMG_WW'(1));
  assign last_px   = x_wrap && (py_q == h_q - C_IMG_HW'(1));

  logic cmp_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      rd_en_q   <= 1'b0;
      rd_sof_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_py_q   <= '0;
      infl_q    <= '0;
    end else begin
      rd_en_q  <= issue;
      rd_sof_q <= issue && (px_q == '0) && (py_q == '0);
      if (issue) begin
        rd_addr_q <= px_q;
        rd_py_q   <= py_q;
      end
      infl_q <= infl_q + IW'(issue) - IW'(cmp_vld_q);
      case (state_q)
        S_IDLE: begin
          pend_q <= 1'b0;
          if (go) begin
            state_q <= S_RUN;
            px_q    <= '0;
            py_q    <= '0;
          end
        end
        S_RUN: begin
          if (fsync) pend_q <= 1'b1;
          if (issue) begin
            if (x_wrap) begin
              px_q <= '0;
              py_q <= py_q + C_IMG_HW'(1);
            end else begin
              px_q <= px_q + C_IMG_WW'(1);
            end
            if (last_px) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fsync) pend_q <= 1'b1;
          if (drained) begin
            pend_q  <= 1'b0;
            state_q <= go ? S_RUN : S_IDLE;
            px_q    <= '0;
            py_q    <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0; h_q <= '0; sv_q <= '0; sm_q <= '0;
      sx0_q <= '0; sx1_q <= '0; sy0_q <= '0; sy1_q <= '0; sc_q <= '0;
    end else if (go) begin
      w_q <= width; h_q <= height; sv_q <= reg_valid; sm_q <= reg_mode;
      sx0_q <= reg_x0; sx1_q <= reg_x1; sy0_q <= reg_y0; sy1_q <= reg_y1; sc_q <= reg_code;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_sof  = rd_sof_q;
  assign rd_addr = rd_addr_q;

  // Coordinates travel alongside the read so they line up with rd_data.
  logic [C_RD_LAT:1]   p_vld_q;
  logic [C_IMG_WW-1:0] p_px_q [1:C_RD_LAT];
  logic [C_IMG_HW-1:0] p_py_q [1:C_RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      p_vld_q <= '0;
    end else begin
      p_vld_q[1] <= rd_en_q;
      for (int k = 2; k <= C_RD_LAT; k++) p_vld_q[k] <= p_vld_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    p_px_q[1] <= rd_addr_q;
    p_py_q[1] <= rd_py_q;
    for (int k = 2; k <= C_RD_LAT; k++) begin
      p_px_q[k] <= p_px_q[k-1];
      p_py_q[k] <= p_py_q[k-1];
    end
  end

  logic [C_IMG_WW-1:0] cx;
  logic [C_IMG_HW-1:0] cy, prof_top, prof_bot;
  logic                prof_vld;
  logic [C_CH-1:0]     hit;
  logic [C_OUT_DW-1:0] code_d;

  assign cx       = p_px_q[C_RD_LAT];
  assign cy       = p_py_q[C_RD_LAT];
  assign prof_vld = rd_data[2*C_IMG_HW];
  assign prof_top = rd_data[2*C_IMG_HW-1 -: C_IMG_HW];
  assign prof_bot = rd_data[C_IMG_HW-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < C_CH; gi++) begin : g_reg
      logic [C_IMG_WW-1:0] x0, x1;
      logic [C_IMG_HW-1:0] y0, y1;
      logic                in_rect, in_band;
      assign x0      = sx0_q[gi*C_IMG_WW +: C_IMG_WW];
      assign x1      = sx1_q[gi*C_IMG_WW +: C_IMG_WW];
      assign y0      = sy0_q[gi*C_IMG_HW +: C_IMG_HW];
      assign y1      = sy1_q[gi*C_IMG_HW +: C_IMG_HW];
      assign in_rect = (x0 <= cx) && (cx <= x1) && (y0 <= cy) && (cy <= y1);
      assign in_band = prof_vld && (prof_top <= cy) && (cy <= prof_bot);
      assign hit[gi] = sv_q[gi] && in_rect && (!sm_q[gi] || in_band);
    end
  endgenerate

  always_comb begin
    code_d = '0;
    for (int i = C_CH - 1; i >= 0; i--) begin
      if (hit[i]) code_d = sc_q[i*C_OUT_DW +: C_OUT_DW];
    end
  end

  logic [C_OUT_DW-1:0] cmp_code_q;
  logic                cmp_first_q, cmp_xlast_q;

  always_ff @(posedge clk) begin
    if (rst) cmp_vld_q <= 1'b0;
    else     cmp_vld_q <= p_vld_q[C_RD_LAT];
  end

  always_ff @(posedge clk) begin
    cmp_code_q  <= code_d;
    cmp_first_q <= (cx == '0) && (cy == '0);
    cmp_xlast_q <= (cx == w_q - C_IMG_WW'(1));
  end

  // FIFO with registered read, then an output register that only loads when the slot frees.
  logic [FW-1:0] mem [DEPTH];
  logic [FW-1:0] rdd_q;
  logic          rdv_q, pop, b_load;

  assign b_load = !m_axis_tvalid || m_axis_tready;
  assign pop    = (fcnt_q != '0) && (!rdv_q || b_load);

  always_ff @(posedge clk) begin
    if (cmp_vld_q) mem[wptr_q] <= {cmp_first_q, cmp_xlast_q, cmp_code_q};
    if (pop)       rdd_q       <= mem[rptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      rdv_q  <= 1'b0;
    end else begin
      if (cmp_vld_q) wptr_q <= wptr_q + C_FIFO_AW'(1);
      if (pop)       rptr_q <= rptr_q + C_FIFO_AW'(1);
      fcnt_q <= fcnt_q + IW'(cmp_vld_q) - IW'(pop);
      if (pop)         rdv_q <= 1'b1;
      else if (b_load) rdv_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (b_load) begin
      m_axis_tvalid <= rdv_q;
      if (rdv_q) {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= rdd_q;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
                                  !(cmp_vld_q && (fcnt_q == IW'(DEPTH))));

`ifdef FSA_MASK_HITCNT_EN
  localparam int HCW = C_IMG_WW + C_IMG_HW;

  logic [C_CH-1:0]        win_d, cmp_win_q;
  logic                   cmp_lastpx_q;
  logic [HCW-1:0]         cnt_q [C_CH];
  logic [C_CH*HCW-1:0]    cnt_d;

  // One-hot of the winning (lowest-index) region.
  always_comb begin
    win_d = '0;
    for (int i = C_CH - 1; i >= 0; i--) begin
      if (hit[i]) win_d = C_CH'(1) << i;
    end
  end

  always_ff @(posedge clk) begin
    cmp_win_q    <= win_d;
    cmp_lastpx_q <= (cx == w_q - C_IMG_WW'(1)) && (cy == h_q - C_IMG_HW'(1));
  end

  generate
    for (gi = 0; gi < C_CH; gi++) begin : g_cnt
      assign cnt_d[gi*HCW +: HCW] = (cmp_vld_q && cmp_win_q[gi] && !(&cnt_q[gi]))
                                    ? cnt_q[gi] + HCW'(1) : cnt_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < C_CH; i++) begin
      if (rst || go) cnt_q[i] <= '0;
      else           cnt_q[i] <= cnt_d[i*HCW +: HCW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt     <= '0;
      hit_cnt_vld <= 1'b0;
    end else begin
      hit_cnt_vld <= cmp_vld_q && cmp_lastpx_q;
      if (cmp_vld_q && cmp_lastpx_q) hit_cnt <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_fsa_mask_stream_mc.sv
// Randomized self-checking bench for fsa_mask_stream_mc with a per-pixel reference model
// and a beat scoreboard. Build with FSA_MASK_HITCNT_EN to also check the hit counters.
module tb_fsa_mask_stream_mc;
  localparam int WW = 12, HH = 12, CH = 4, DW = 8, RL = 3, FA = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [WW-1:0] width;
  logic [HH-1:0] height;
  logic fsync;
  logic [CH-1:0] rv, rm;
  logic [CH*WW-1:0] reg_x0, reg_x1;
  logic [CH*HH-1:0] reg_y0, reg_y1;
  logic [CH*DW-1:0] reg_code;
  logic rd_sof, rd_en;
  logic [WW-1:0] rd_addr;
  logic [2*HH:0] rd_data;
  logic tvalid, tuser, tlast, tready;
  logic [DW-1:0] tdata;
`ifdef FSA_MASK_HITCNT_EN
  logic [CH*(WW+HH)-1:0] hit_cnt;
  logic hit_cnt_vld;
`endif

  fsa_mask_stream_mc #(.C_IMG_WW(WW), .C_IMG_HW(HH), .C_CH(CH), .C_OUT_DW(DW),
                       .C_RD_LAT(RL), .C_FIFO_AW(FA)) dut (
    .clk(clk), .rst(rst), .width(width), .height(height), .fsync(fsync),
    .reg_valid(rv), .reg_mode(rm), .reg_x0(reg_x0), .reg_x1(reg_x1),
    .reg_y0(reg_y0), .reg_y1(reg_y1), .reg_code(reg_code),
    .rd_sof(rd_sof), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata), .m_axis_tuser(tuser),
    .m_axis_tlast(tlast), .m_axis_tready(tready)
`ifdef FSA_MASK_HITCNT_EN
    , .hit_cnt(hit_cnt), .hit_cnt_vld(hit_cnt_vld)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Region configuration, packed onto the DUT ports.
  logic [WW-1:0] rx0 [CH], rx1 [CH];
  logic [HH-1:0] ry0 [CH], ry1 [CH];
  logic [DW-1:0] rc  [CH];

  always_comb begin
    reg_x0 = '0; reg_x1 = '0; reg_y0 = '0; reg_y1 = '0; reg_code = '0;
    for (int i = 0; i < CH; i++) begin
      reg_x0[i*WW +: WW]   = rx0[i];
      reg_x1[i*WW +: WW]   = rx1[i];
      reg_y0[i*HH +: HH]   = ry0[i];
      reg_y1[i*HH +: HH]   = ry1[i];
      reg_code[i*DW +: DW] = rc[i];
    end
  end

  // Profile RAM with C_RD_LAT read latency; garbage when not read.
  logic [2*HH:0] prof  [0:4095];
  logic [2*HH:0] rpipe [RL];
  assign rd_data = rpipe[RL-1];

  always @(posedge clk) begin
    rpipe[0] <= rd_en ? prof[rd_addr] : 25'($urandom);
    for (int k = 1; k < RL; k++) rpipe[k] <= rpipe[k-1];
  end

  // Reference: first enabled region (lowest index) whose rectangle and optional band contain the pixel.
  function automatic logic [DW-1:0] model_code(input int x, input int y);
    for (int i = 0; i < CH; i++) begin
      int pt, pb;
      if (!rv[i]) continue;
      if (x < int'(rx0[i]) || x > int'(rx1[i]) || y < int'(ry0[i]) || y > int'(ry1[i])) continue;
      pt = int'(prof[x][2*HH-1 -: HH]);
      pb = int'(prof[x][HH-1:0]);
      if (rm[i] && !(prof[x][2*HH] && y >= pt && y <= pb)) continue;
      return rc[i];
    end
    return '0;
  endfunction

  logic [DW+1:0] exp_q [$];
  logic [DW-1:0] got_px [0:2047];
  int beat_cnt, last_cnt, sof_cnt, rdy_pct;
`ifdef FSA_MASK_HITCNT_EN
  int hc_pulses;
  logic [CH*(WW+HH)-1:0] hc_val;
`endif

  task automatic push_frame(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        exp_q.push_back({(x == 0 && y == 0), (x == w - 1), model_code(x, y)});
  endtask

  task automatic pulse_fsync();
    fsync = 1'b1;
    @(posedge clk); #1;
    fsync = 1'b0;
  endtask

  task automatic start_frame(input int w, input int h);
    width  = WW'(w);
    height = HH'(h);
    push_frame(w, h);
    pulse_fsync();
  endtask

  task automatic clear_stats();
    beat_cnt = 0; last_cnt = 0; sof_cnt = 0;
`ifdef FSA_MASK_HITCNT_EN
    hc_pulses = 0;
`endif
  endtask

  task automatic clear_regions();
    rv = '0; rm = '0;
    for (int i = 0; i < CH; i++) begin
      rx0[i] = '0; rx1[i] = '0; ry0[i] = '0; ry1[i] = '0; rc[i] = '0;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    repeat (30) @(posedge clk);
    #1;
    $display("frame %s: beats=%0d tlast=%0d sof=%0d cycles=%0d", tag, beat_cnt, last_cnt, sof_cnt, n);
  endtask

  // Ready generator.
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Output monitor / scoreboard, sampled on the falling edge.
  initial begin
    logic          prev_stall;
    logic [DW+1:0] prev_out;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("hold", 64'({tvalid, tuser, tlast, tdata}), 64'({1'b1, prev_out}));
        if (rd_sof) sof_cnt++;
        if (tvalid && tready) begin
          if (exp_q.size() == 0) check("extra_beat", 64'(1), 64'(0));
          else check("beat", 64'({tuser, tlast, tdata}), 64'(exp_q.pop_front()));
          if (beat_cnt < 2048) got_px[beat_cnt] = tdata;
          beat_cnt++;
          if (tlast) last_cnt++;
        end
`ifdef FSA_MASK_HITCNT_EN
        if (hit_cnt_vld) begin
          hc_pulses++;
          hc_val = hit_cnt;
        end
`endif
        prev_stall = tvalid && !tready;
        prev_out   = {tuser, tlast, tdata};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1);
  end

  initial begin
    width = '0; height = '0; fsync = 1'b0; rdy_pct = 100;
    for (int i = 0; i < 4096; i++) prof[i] = '0;
    clear_regions();
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_tuser",  64'(tuser),  64'(0));
    check("rst_tlast",  64'(tlast),  64'(0));
    check("rst_tdata",  64'(tdata),  64'(0));
    check("rst_rd_en",  64'(rd_en),  64'(0));
    check("rst_rd_sof", 64'(rd_sof), 64'(0));
    @(posedge clk); #1;

    // Basic 8x4 frame, one rectangle.
    rv = 4'b0001; rx0[0] = 2; rx1[0] = 5; ry0[0] = 1; ry1[0] = 2; rc[0] = 8'h11;
    clear_stats();
    start_frame(8, 4);
    wait_done("basic", 2000);
    check("basic_beats", 64'(beat_cnt), 64'(32));
    check("basic_tlast", 64'(last_cnt), 64'(4));
    check("basic_sof",   64'(sof_cnt),  64'(1));
    check("basic_px3_1", 64'(got_px[11]), 64'(8'h11));
    check("basic_px1_1", 64'(got_px[9]),  64'(0));
    check("basic_px3_3", 64'(got_px[27]), 64'(0));
`ifdef FSA_MASK_HITCNT_EN
    check("hitcnt_pulses", 64'(hc_pulses), 64'(1));
    check("hitcnt0", 64'(hc_val[0 +: WW+HH]), 64'(8));
    check("hitcnt1", 64'(hc_val[WW+HH +: WW+HH]), 64'(0));
`endif

    // Priority between two overlapping regions.
    clear_regions();
    rv = 4'b0011;
    rx0[0] = 2; rx1[0] = 3; ry0[0] = 1; ry1[0] = 1; rc[0] = 8'h01;
    rx0[1] = 3; rx1[1] = 6; ry0[1] = 0; ry1[1] = 2; rc[1] = 8'h02;
    clear_stats();
    start_frame(8, 4);
    wait_done("prio_a", 2000);
    check("prio_both", 64'(got_px[11]), 64'(8'h01));
    rv = 4'b0010;
    clear_stats();
    start_frame(8, 4);
    wait_done("prio_b", 2000);
    check("prio_r1", 64'(got_px[11]), 64'(8'h02));

    // Profile band mode.
    clear_regions();
    rv = 4'b0001; rm = 4'b0001;
    rx0[0] = 0; rx1[0] = 7; ry0[0] = 0; ry1[0] = 3; rc[0] = 8'h33;
    prof[4] = {1'b1, 12'd1, 12'd2};
    prof[5] = {1'b0, 12'd0, 12'd3};
    clear_stats();
    start_frame(8, 4);
    wait_done("profile", 2000);
    check("prof_c4_r1", 64'(got_px[12]), 64'(8'h33));
    check("prof_c4_r2", 64'(got_px[20]), 64'(8'h33));
    check("prof_c4_r0", 64'(got_px[4]),  64'(0));
    check("prof_c4_r3", 64'(got_px[28]), 64'(0));
    check("prof_c5_r1", 64'(got_px[13]), 64'(0));

    // Random regions and profile under 30% ready.
    for (int i = 0; i < CH; i++) begin
      rv[i]  = 1'($urandom_range(0, 1));
      rm[i]  = 1'($urandom_range(0, 1));
      rx0[i] = WW'($urandom_range(0, 70));
      rx1[i] = WW'($urandom_range(0, 70));
      ry0[i] = HH'($urandom_range(0, 18));
      ry1[i] = HH'($urandom_range(0, 18));
      rc[i]  = DW'($urandom_range(1, 255));
    end
    rv[0] = 1'b1; rm[0] = 1'b0;
    for (int x = 0; x < 64; x++)
      prof[x] = {1'($urandom_range(0, 1)), HH'($urandom_range(0, 17)), HH'($urandom_range(0, 17))};
    rdy_pct = 30;
    clear_stats();
    start_frame(64, 16);
    wait_done("backpressure", 20000);
    check("bp_beats", 64'(beat_cnt), 64'(1024));
    check("bp_tlast", 64'(last_cnt), 64'(16));

    // Back-to-back: fsync mid-frame queues one more frame; a second extra fsync adds nothing.
    rdy_pct = 100;
    clear_stats();
    start_frame(16, 4);
    repeat (5) @(posedge clk); #1;
    push_frame(16, 4);
    pulse_fsync();
    repeat (3) @(posedge clk); #1;
    pulse_fsync();
    wait_done("b2b", 4000);
    check("b2b_beats", 64'(beat_cnt), 64'(128));
    check("b2b_sof",   64'(sof_cnt),  64'(2));

    // Reset mid-frame, then a clean frame.
    rdy_pct = 70;
    clear_stats();
    start_frame(16, 8);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_tvalid", 64'(tvalid), 64'(0));
    check("abort_rd_en",  64'(rd_en),  64'(0));
    repeat (10) @(posedge clk); #1;
    check("abort_idle", 64'(rd_en), 64'(0));
    clear_stats();
    start_frame(16, 8);
    wait_done("after_abort", 4000);
    check("abort_beats", 64'(beat_cnt), 64'(128));
    check("abort_sof",   64'(sof_cnt),  64'(1));

    // Degenerate sizes.
    rdy_pct = 100;
    clear_stats();
    start_frame(0, 4);
    start_frame(5, 0);
    repeat (60) @(posedge clk); #1;
    check("zero_beats", 64'(beat_cnt), 64'(0));
    check("zero_sof",   64'(sof_cnt),  64'(0));
    clear_stats();
    start_frame(1, 3);
    wait_done("w1", 2000);
    check("w1_beats", 64'(beat_cnt), 64'(3));
    check("w1_tlast", 64'(last_cnt), 64'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsa_mask_stream_mc.md
Name: fsa_mask_stream_mc

Overview:
- Multi-region successor of the single-fibre mask streamer.
- Scans a frame raster and reads a per-column profile from block RAM: valid bit, top row, bottom row, indexed by column.
- Tests each pixel against C_CH independently configured rectangular regions and emits a per-pixel class code as an AXI4-Stream video frame.
- Sits between the FSA result registers and display overlay/VDMA; output is fully backpressure-safe through an internal FIFO.

Parameters:
- C_IMG_WW, 12: width of image x coordinate and width input; also the profile RAM address width.
- C_IMG_HW, 12: width of image y coordinate and height input.
- C_CH, 4: number of regions (1..8); a lower index has higher priority.
- C_OUT_DW, 8: output pixel/class code width.
- C_RD_LAT, 3: cycles from rd_en to valid rd_data (1..4).
- C_FIFO_AW, 4: log2 of FIFO depth.

Ports:
- clk  in  1: clock.
- rst  in  1: synchronous active-high reset.
- width  in  C_IMG_WW: frame width, sampled at frame start.
- height  in  C_IMG_HW: frame height, sampled at frame start.
- fsync  in  1: frame-start request pulse.
- reg_valid  in  C_CH: per-region enable.
- reg_mode  in  C_CH: 0 = rectangle only; 1 = rectangle AND profile band.
- reg_x0, reg_x1  in  C_CH*C_IMG_WW: inclusive x bounds, packed, channel i at [i*W +: W].
- reg_y0, reg_y1  in  C_CH*C_IMG_HW: inclusive y bounds, packed.
- reg_code  in  C_CH*C_OUT_DW: class code emitted on hit.
- rd_sof  out  1: pulses with the first rd_en of a frame.
- rd_en  out  1: profile RAM read strobe.
- rd_addr  out  C_IMG_WW: column address (= px).
- rd_data  in  2*C_IMG_HW+1: bit [2*C_IMG_HW] = valid, [2*C_IMG_HW-1:C_IMG_HW] = top, [C_IMG_HW-1:0] = bot.
- m_axis_tvalid/tdata[C_OUT_DW]/tuser/tlast  out: video stream.
- m_axis_tready  in  1.

Behaviour:
- Reset (rst=1, synchronous):
  - rd_en, rd_sof, m_axis_tvalid, tuser, tlast = 0; tdata = 0.
  - FIFO emptied; px = py = 0; state IDLE; pending = 0.
  - Region shadow registers cleared (all invalid).
  - Reset mid-frame discards all in-flight pixels; no partial tlast is emitted.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN when fsync (or pending) is set and width!=0 and height!=0:
  - width, height and all reg_* inputs are latched into shadow registers.
  - pending is cleared.
- fsync with width==0 or height==0: frame skipped, stays IDLE, no output.
- fsync while in RUN or DRAIN: sets pending. The current frame is never truncated. pending=1 with a further fsync stays 1 (no queue).
- RUN issues reads:
  - rd_en = 1 in every cycle where FIFO free slots >= C_RD_LAT+3 (counting in-flight reads).
  - px increments, wrapping at width-1; py increments on x wrap.
  - On the last pixel (px=width-1, py=height-1) the next state is DRAIN.
- DRAIN -> IDLE when all in-flight pixels have been written to the FIFO.
  - If pending is set, go straight to RUN on the next cycle instead.
- Pipeline:
  - px/py/first/xlast are delayed C_RD_LAT cycles alongside the read.
  - Compare stage: 1 cycle. FIFO write: 1 cycle.
  - Latency rd_en -> FIFO write = C_RD_LAT+2.
  - FIFO empty -> m_axis_tvalid: 2 cycles (FIFO read + output register).
- Hit test for region i:
  - reg_valid[i] && y0<=py<=y1 && x0<=px<=x1.
  - When reg_mode[i]=1, additionally requires rd_valid && top<=py<=bot.
  - All comparisons are unsigned at full coordinate width.
  - x0>x1 or y0>y1 means the region never hits.
- tdata = reg_code of the lowest-index hit region; 0 when nothing hits.
- tuser = 1 on pixel (0,0) only. tlast = 1 on px=width-1. width=1 means every pixel has tlast.
- AXIS rules:
  - Beat transfers on tvalid&&tready.
  - tdata/tuser/tlast stay stable while tvalid=1 and tready=0.
  - Full throughput of 1 pixel/clk with continuous tready.
- FIFO never overflows; overflow is a verification assertion.

Optional Feature:
- Macro FSA_MASK_HITCNT_EN.
- When defined:
  - Adds output hit_cnt (C_CH*(C_IMG_WW+C_IMG_HW) bits) and output hit_cnt_vld (1 bit).
  - Per-region counters count pixels whose winning region is i.
  - Counters clear at frame start; they saturate at all-ones.
  - Counts latch into hit_cnt with a 1-cycle hit_cnt_vld pulse the cycle after the tlast of the last line is written to the FIFO.
  - hit_cnt and hit_cnt_vld reset to 0.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Basic frame:
  - Stimulus: width=8, height=4, region0 x0=2,x1=5,y0=1,y1=2, mode 0, code 0x11; tready=1.
  - Required: 32 beats; tuser only on beat 0; tlast on beats 7,15,23,31; tdata=0x11 exactly at x2..5 in rows 1..2, else 0.
- Priority:
  - Stimulus: region0 code 0x01 and region1 code 0x02 overlap at (3,1).
  - Required: (3,1) yields 0x01; disabling region0 yields 0x02.
- Profile mode:
  - Stimulus: mode=1, RAM column 4 valid=1, top=1, bot=2; column 5 valid=0.
  - Required: hits at column 4 rows 1..2 only; column 5 always 0.
- Backpressure:
  - Stimulus: random tready at 30% duty, 64x16 frame.
  - Required: 1024 beats in order, values match the golden model, no FIFO overflow, outputs stable while stalled.
- Back-to-back and abort:
  - Stimulus: fsync mid-frame.
  - Required: the current frame completes, then the next frame starts with tuser.
  - Stimulus: rst mid-frame.
  - Required: tvalid=0 next cycle; a subsequent fsync produces a clean full frame.
- Degenerate sizes:
  - Stimulus: width=0 -> required: no beats. width=1, height=3 -> required: 3 beats, all tlast.
  - With FSA_MASK_HITCNT_EN: the basic frame gives hit_cnt[0]=8.
